// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI byte engine between two requesters.
// Requester 0 is the CPU peripheral port and requester 1 is the flash/boot
// loader. Each requester owns one chip select. The arbiter adds CS setup and
// hold timing, multi-byte bursts with CS held low, round-robin grants and an
// abort when the engine never acknowledges spi_start.
module spi_arbiter #(
  parameter int CS_SETUP      = 4,
  parameter int CS_HOLD       = 4,
  parameter int START_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_tx,
  input  logic       req0_last,
  output logic       req0_ack,
  input  logic       req1_valid,
  input  logic [7:0] req1_tx,
  input  logic       req1_last,
  output logic       req1_ack,
  output logic [7:0] rx_data,
  output logic       err,
  output logic       spi_start,
  output logic [7:0] spi_data_tx,
  input  logic [7:0] spi_data_rx,
  input  logic       spi_busy,
  output logic [1:0] spi_cs_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_START,
    S_WAIT,
    S_NEXT,
    S_HOLD
  } state_t;

  localparam logic [7:0] SETUP_END   = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_END    = 8'(CS_HOLD - 1);
  localparam logic [7:0] TIMEOUT_END = 8'(START_TIMEOUT);

  state_t     state, state_nxt;
  logic       owner, owner_nxt;
  logic       last_owner, last_owner_nxt;
  logic       last_r, last_nxt;
  logic       busy_r;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] cs_n_nxt;
  logic [1:0] ack_nxt;
  logic       start_nxt;
  logic       err_nxt;
  logic [7:0] data_tx_nxt;
  logic [7:0] rx_nxt;

  // Grant candidate in IDLE, and the current owner's request lines.
  logic       grant;
  logic       own_valid;
  logic       own_last;
  logic [7:0] own_tx;
  logic [1:0] own_ack;
  logic       ack_any;

  assign grant     = (req0_valid && req1_valid) ? ~last_owner : req1_valid;
  assign own_valid = owner ? req1_valid : req0_valid;
  assign own_last  = owner ? req1_last  : req0_last;
  assign own_tx    = owner ? req1_tx    : req0_tx;
  assign own_ack   = owner ? 2'b10      : 2'b01;
  assign ack_any   = req0_ack | req1_ack;

  // Register the engine busy flag; every decision looks at busy_r only.
  // NOTE: busy_r is deliberately outside reset so it keeps tracking an engine
  // that is still finishing a byte while the arbiter is held in reset.
  always_ff @(posedge clk) begin
    busy_r <= spi_busy;
  end

  // State and registered outputs, with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      last_r      <= 1'b0;
      cnt         <= 8'd0;
      spi_cs_n    <= 2'b11;
      spi_start   <= 1'b0;
      spi_data_tx <= 8'd0;
      rx_data     <= 8'd0;
      err         <= 1'b0;
      req0_ack    <= 1'b0;
      req1_ack    <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_owner  <= last_owner_nxt;
      last_r      <= last_nxt;
      cnt         <= cnt_nxt;
      spi_cs_n    <= cs_n_nxt;
      spi_start   <= start_nxt;
      spi_data_tx <= data_tx_nxt;
      rx_data     <= rx_nxt;
      err         <= err_nxt;
      req0_ack    <= ack_nxt[0];
      req1_ack    <= ack_nxt[1];
    end
  end

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    // NOTE: every value gets a default before the case so that no path can
    // leave one unassigned and infer a latch.
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    last_nxt       = last_r;
    cnt_nxt        = cnt;
    cs_n_nxt       = spi_cs_n;
    start_nxt      = spi_start;
    data_tx_nxt    = spi_data_tx;
    rx_nxt         = rx_data;
    err_nxt        = err;
    ack_nxt        = 2'b00;

    case (state)
      S_IDLE: begin
        // The engine is never reset, so wait until it has gone quiet.
        if (!busy_r && (req0_valid || req1_valid)) begin
          owner_nxt      = grant;
          last_owner_nxt = grant;
          data_tx_nxt    = grant ? req1_tx   : req0_tx;
          last_nxt       = grant ? req1_last : req0_last;
          cs_n_nxt       = grant ? 2'b01     : 2'b10;
          cnt_nxt        = 8'd0;
          state_nxt      = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt == SETUP_END) begin
          start_nxt = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = S_START;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      S_START: begin
        if (busy_r) begin
          start_nxt = 1'b0;
          state_nxt = S_WAIT;
        end else if (cnt == TIMEOUT_END) begin
          start_nxt = 1'b0;
          ack_nxt   = own_ack;
          err_nxt   = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = S_HOLD;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      S_WAIT: begin
        if (!busy_r) begin
          rx_nxt    = spi_data_rx;
          ack_nxt   = own_ack;
          err_nxt   = 1'b0;
          cnt_nxt   = 8'd0;
          state_nxt = last_r ? S_HOLD : S_NEXT;
        end
      end

      S_NEXT: begin
        // The ack cycle is skipped: the requester updates its lines on that edge.
        if (!ack_any && own_valid) begin
          data_tx_nxt = own_tx;
          last_nxt    = own_last;
          start_nxt   = 1'b1;
          cnt_nxt     = 8'd0;
          state_nxt   = S_START;
        end
      end

      S_HOLD: begin
        if (cnt == HOLD_END) begin
          cs_n_nxt  = 2'b11;
          cnt_nxt   = 8'd0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: self-checking bench for spi_arbiter with a loopback engine
// model (data_rx = last data_tx) and a per-requester expected-ack scoreboard.
module tb_spi_arbiter;

  localparam int CS_SETUP      = 4;
  localparam int CS_HOLD       = 4;
  localparam int START_TIMEOUT = 255;
  localparam int ACK_LIMIT     = 2000;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_last, req0_ack;
  logic [7:0] req0_tx;
  logic       req1_valid, req1_last, req1_ack;
  logic [7:0] req1_tx;
  logic [7:0] rx_data;
  logic       err;
  logic       spi_start;
  logic [7:0] spi_data_tx;
  logic [7:0] spi_data_rx;
  logic       spi_busy;
  logic [1:0] spi_cs_n;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ack_log[$];
  int   total = 0;
  int   bad = 0;
  int   ack_cnt0 = 0;
  int   ack_cnt1 = 0;
  int   cs_both_low = 0;
  int   both_ack = 0;

  // Engine model configuration and state.
  int         eng_len = 8;
  int         eng_lat = 1;
  bit         eng_dead = 1'b0;
  int         eng_cnt = 0;
  int         lat_cnt = 0;
  int         eng_xfers = 0;
  int         early_drop = 0;
  logic [7:0] eng_shift = 8'd0;

  spi_arbiter #(
    .CS_SETUP     (CS_SETUP),
    .CS_HOLD      (CS_HOLD),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_tx    (req0_tx),
    .req0_last  (req0_last),
    .req0_ack   (req0_ack),
    .req1_valid (req1_valid),
    .req1_tx    (req1_tx),
    .req1_last  (req1_last),
    .req1_ack   (req1_ack),
    .rx_data    (rx_data),
    .err        (err),
    .spi_start  (spi_start),
    .spi_data_tx(spi_data_tx),
    .spi_data_rx(spi_data_rx),
    .spi_busy   (spi_busy),
    .spi_cs_n   (spi_cs_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
    if (r == 0) begin
      req0_valid = v; req0_tx = d; req0_last = l;
    end else begin
      req1_valid = v; req1_tx = d; req1_last = l;
    end
  endtask

  function automatic logic get_ack(input int r);
    return (r == 0) ? req0_ack : req1_ack;
  endfunction

  // Pop the oldest expectation for requester r and compare it with the ack.
  task automatic sb_pop(input int r);
    exp_t e;
    if ((r == 0 && q0.size() == 0) || (r == 1 && q1.size() == 0)) begin
      check($sformatf("ack%0d_unexpected", r), 32'd1, 32'd0);
    end else begin
      e = (r == 0) ? q0.pop_front() : q1.pop_front();
      if (!e.err) check($sformatf("rx%0d", r), 32'(rx_data), 32'(e.data));
      check($sformatf("err%0d", r), 32'(err), 32'(e.err));
    end
  endtask

  // Send a burst of n bytes (byte i in bytes[8i+:8]); last flag on the final one.
  task automatic send_burst(input int r, input logic [31:0] bytes, input int n,
                            input logic exp_err);
    exp_t       e;
    logic [7:0] d;
    int         k;
    for (int i = 0; i < n; i++) begin
      d      = bytes[8*i +: 8];
      e.data = d;
      e.err  = exp_err;
      if (r == 0) q0.push_back(e); else q1.push_back(e);
      set_req(r, 1'b1, d, (i == n - 1));
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!get_ack(r) && k < ACK_LIMIT);
      if (!get_ack(r)) check($sformatf("ack_wait_r%0d_b%0d", r, i), 32'd0, 32'd1);
    end
    set_req(r, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic wait_cs(input logic [1:0] v, input string tag);
    int k = 0;
    while (spi_cs_n !== v && k < ACK_LIMIT) begin
      @(negedge clk);
      k++;
    end
    if (spi_cs_n !== v) check(tag, 32'(spi_cs_n), 32'(v));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_req(0, 1'b0, 8'd0, 1'b0);
    set_req(1, 1'b0, 8'd0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Engine model: start after eng_lat cycles of spi_start, busy for eng_len.
  initial begin
    spi_busy    = 1'b0;
    spi_data_rx = 8'd0;
    forever begin
      @(negedge clk);
      if (spi_busy) begin
        if (eng_cnt <= 1) begin
          spi_busy    = 1'b0;
          spi_data_rx = eng_shift;
        end else begin
          eng_cnt--;
        end
      end else if (spi_start && !eng_dead) begin
        lat_cnt++;
        if (lat_cnt >= eng_lat) begin
          spi_busy  = 1'b1;
          eng_cnt   = eng_len;
          eng_shift = spi_data_tx;
          eng_xfers++;
          lat_cnt   = 0;
        end
      end else begin
        if (lat_cnt > 0) early_drop++;
        lat_cnt = 0;
      end
    end
  end

  // Ack monitor and chip-select exclusivity watch.
  initial begin
    forever begin
      @(negedge clk);
      if (spi_cs_n === 2'b00) cs_both_low++;
      if (req0_ack && req1_ack) both_ack++;
      if (req0_ack) begin ack_cnt0++; ack_log.push_back(0); sb_pop(0); end
      if (req1_ack) begin ack_cnt1++; ack_log.push_back(1); sb_pop(1); end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, a0, x0, viol;
    logic [1:0] cs_after;
    int exp_ord2[4] = '{0, 1, 0, 1};
    int exp_ord3[4] = '{1, 1, 1, 0};

    // Reset values.
    reset = 1'b1;
    set_req(0, 1'b0, 8'd0, 1'b0);
    set_req(1, 1'b0, 8'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_cs_n", 32'(spi_cs_n), 32'h3);
    check("rst_start", 32'(spi_start), 32'd0);
    check("rst_data_tx", 32'(spi_data_tx), 32'd0);
    check("rst_acks", 32'({req1_ack, req0_ack}), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rx", 32'(rx_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: single byte, setup/hold timing and loopback data.
    a0 = ack_cnt0;
    q0.push_back('{data: 8'hA5, err: 1'b0});
    set_req(0, 1'b1, 8'hA5, 1'b1);
    wait_cs(2'b10, "t1_cs_low");
    n = 0;
    while (spi_start == 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t1_setup_cycles", 32'(n), 32'(CS_SETUP));
    k = 0;
    while (!req0_ack && k < ACK_LIMIT) begin
      @(negedge clk);
      k++;
    end
    check("t1_ack_seen", 32'(req0_ack), 32'd1);
    set_req(0, 1'b0, 8'd0, 1'b0);
    n = 0;
    while (spi_cs_n !== 2'b11 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t1_hold_cycles", 32'(n), 32'(CS_HOLD));
    repeat (2) @(negedge clk);
    check("t1_ack_count", 32'(ack_cnt0 - a0), 32'd1);

    // 2: both valid right after reset -> 0,1,0,1.
    do_reset();
    ack_log.delete();
    fork
      begin
        send_burst(0, 32'h11, 1, 1'b0);
        send_burst(0, 32'h33, 1, 1'b0);
      end
      begin
        send_burst(1, 32'h22, 1, 1'b0);
        send_burst(1, 32'h44, 1, 1'b0);
      end
    join
    repeat (2) @(negedge clk);
    check("t2_ack_total", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      check($sformatf("t2_order_%0d", i), 32'(ack_log[i]), 32'(exp_ord2[i]));
    wait_cs(2'b11, "t2_cs_idle");

    // 3: req1 three-byte burst while req0 waits.
    ack_log.delete();
    viol = 0;
    cs_after = 2'b00;
    fork
      send_burst(1, 32'h030201, 3, 1'b0);
      begin
        wait_cs(2'b01, "t3_cs1_low_b");
        send_burst(0, 32'h5A, 1, 1'b0);
      end
      begin
        int c = 0;
        int m = 0;
        wait_cs(2'b01, "t3_cs1_low_c");
        while (c < 3 && m < ACK_LIMIT) begin
          if (spi_cs_n !== 2'b01) viol++;
          if (req1_ack) c++;
          m++;
          if (c < 3) @(negedge clk);
        end
        while (spi_cs_n === 2'b01 && m < ACK_LIMIT) begin
          @(negedge clk);
          m++;
        end
        cs_after = spi_cs_n;
      end
    join
    repeat (2) @(negedge clk);
    check("t3_cs1_continuous", 32'(viol), 32'd0);
    check("t3_cs_after_burst", 32'(cs_after), 32'h3);
    check("t3_ack_total", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      check($sformatf("t3_order_%0d", i), 32'(ack_log[i]), 32'(exp_ord3[i]));
    wait_cs(2'b11, "t3_cs_idle");

    // 4: engine never goes busy -> abort with err after the timeout.
    eng_dead = 1'b1;
    x0 = eng_xfers;
    n = 0;
    fork
      send_burst(0, 32'h77, 1, 1'b1);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (spi_start) n++;
        end
      end
    join
    // Counter runs 0..START_TIMEOUT with spi_start high, then it drops.
    check("t4_start_len", 32'(n), 32'(START_TIMEOUT + 1));
    wait_cs(2'b11, "t4_cs_wait");
    check("t4_cs_release", 32'(spi_cs_n), 32'h3);
    check("t4_no_xfer", 32'(eng_xfers - x0), 32'd0);
    eng_dead = 1'b0;

    // 5: reset while waiting on the engine.
    eng_len = 30;
    q0.push_back('{data: 8'h3C, err: 1'b0});
    set_req(0, 1'b1, 8'h3C, 1'b1);
    k = 0;
    while (!(spi_cs_n === 2'b10 && !spi_start && spi_busy) && k < ACK_LIMIT) begin
      @(negedge clk);
      k++;
    end
    check("t5_reached_wait", 32'(spi_busy && spi_cs_n === 2'b10), 32'd1);
    reset = 1'b1;
    set_req(0, 1'b0, 8'd0, 1'b0);
    q0.delete();
    @(negedge clk);
    check("t5_cs_after_reset", 32'(spi_cs_n), 32'h3);
    check("t5_no_ack", 32'({req1_ack, req0_ack}), 32'd0);
    check("t5_engine_still_busy", 32'(spi_busy), 32'd1);
    reset = 1'b0;
    viol = 0;
    fork
      send_burst(0, 32'hC3, 1, 1'b0);
      begin
        int m = 0;
        while (spi_busy && m < ACK_LIMIT) begin
          if (spi_cs_n !== 2'b11) viol++;
          @(negedge clk);
          m++;
        end
      end
    join
    check("t5_no_grant_while_busy", 32'(viol), 32'd0);
    wait_cs(2'b11, "t5_cs_idle");

    // 6: slow engine, 2-byte burst, start must be held until busy.
    eng_len = 60;
    eng_lat = 5;
    x0 = eng_xfers;
    send_burst(0, 32'h7E81, 2, 1'b0);
    wait_cs(2'b11, "t6_cs_idle");
    repeat (4) @(negedge clk);
    check("t6_xfers", 32'(eng_xfers - x0), 32'd2);
    check("t6_early_drop", 32'(early_drop), 32'd0);

    // Global invariants and scoreboard drain.
    check("cs_both_low", 32'(cs_both_low), 32'd0);
    check("both_acks", 32'(both_ack), 32'd0);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
